dpsf_fifo_ce: RTL and testbench
===============================

# dpsf_fifo_ce

Parametrised dual-port synchronous FIFO, the successor to the fixed 16×16 FIFO used in the UART/SPI datapaths. It adds parametrised width and depth, a selectable first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty flags, a synchronous clear, and sticky overflow/underflow error flags. It is a single-clock block that sits between a peripheral shift engine and the core bus interface.

## Interface
- pWidth, 16, data width in bits
- pAddr, 4, address bits; depth = 2**pAddr entries (legal range 2..10)
- pFWFT, 0, 0 = registered read (DO valid the cycle after RE); 1 = first-word-fall-through
- pAFLvl, 12, AF asserts when Cnt >= pAFLvl (1..depth)
- pAELvl, 4, AE asserts when Cnt <= pAELvl (0..depth-1)
- Clk  in  1  rising-edge clock, sole clock
- nRst  in  1  asynchronous, active-low reset
- Clr  in  1  synchronous clear: empties FIFO, clears OVF/UNF, and has priority over WE/RE
- WE  in  1  write request
- RE  in  1  read request
- DI  in  pWidth  write data
- DO  out  pWidth  read data
- FF  out  1  full (Cnt == depth)
- EF  out  1  empty (Cnt == 0)
- HF  out  1  half full (Cnt >= depth/2)
- AF  out  1  almost full
- AE  out  1  almost empty
- OVF  out  1  sticky: write attempted while full and not accepted
- UNF  out  1  sticky: read attempted while empty
- Cnt  out  pAddr+1  occupancy, 0..depth

## Operation
- Storage: 2**pAddr × pWidth RAM; write pointer WA and read pointer RA, each pAddr bits, wrap modulo depth with no skip at wrap.
- Accept rules, evaluated each rising Clk edge:
  - Rd = RE & ~EF.
  - Wr = WE & (~FF | Rd). A write while full is accepted only when a read is accepted in the same cycle.
  - Rd & Wr: both pointers advance and Cnt is unchanged.
  - When empty, Rd = 0 even if WE = 1 in the same cycle. The write is still accepted and UNF is set.
- Cnt: +1 on Wr only, −1 on Rd only, unchanged otherwise. It never exceeds depth and never underflows.
- Flags are decoded combinationally from the registered Cnt. All flags update in the same cycle as Cnt.
- Errors:
  - OVF sets on WE & FF & ~Rd.
  - UNF sets on RE & EF.
  - Both hold until Clr or nRst.
  - A rejected write or read leaves RAM, pointers and Cnt untouched.
- Read modes:
  - pFWFT = 0: on Rd, DO is loaded from RAM[RA] and RA advances. DO holds its value otherwise, including through a rejected read.
  - pFWFT = 1: DO = RAM[RA] continuously and is valid whenever EF = 0. Rd pops the head, and DO shows the next entry after the edge. When EF = 1, DO is don't-care.
- Clr: WA, RA and Cnt go to 0; OVF and UNF go to 0; DO goes to 0 in mode 0. RAM contents are not cleared. WE and RE are ignored in the Clr cycle.
- Reset (nRst low), asynchronous:
  - Cnt = 0, WA = 0, RA = 0.
  - EF = 1, FF = 0, HF = 0, AF = 0 (pAFLvl ≥ 1), AE = 1.
  - OVF = 0, UNF = 0, DO = 0 (mode 0).
  - Deassertion is synchronised externally. An operation in flight when nRst asserts is discarded.

## Timing
- Write latency: data written at edge N is readable at edge N+1.
  - Mode 0: DO shows it after the RE edge, earliest edge N+1.
  - Mode 1: DO shows it immediately after edge N if the FIFO was empty.
- Flags and Cnt change only on the rising Clk edge, or asynchronously on nRst.
- Back-to-back single-cycle WE and/or RE are supported every cycle with no wait states.
- Full + RE & WE: Cnt stays at depth and FF stays 1. The oldest word is output and the new word is stored at the freed slot.
- Empty + RE & WE: EF drops after the edge, Cnt = 1, UNF = 1.

## Test plan
- Reset with nRst = 0 mid-stream (Cnt = 5) -> Cnt, OVF, UNF and DO go to 0 and EF = 1, AE = 1 asynchronously, before the next Clk edge.
- Defaults (16×16, mode 0): write 16'h1111..16'h0000 (16 words) -> Cnt = 16, FF = 1, HF = 1 from Cnt = 8, AF = 1 from Cnt = 12, AE = 0 from Cnt = 5. A 17th write of 16'h0001 -> OVF = 1, Cnt stays 16. Then read 16 times -> DO sequence 1111, 2222, …, 0000, EF = 1. A 17th read -> UNF = 1 and DO holds 16'h0000.
- Full FIFO with simultaneous WE = 1, RE = 1, DI = 16'h8001 -> DO = oldest word, Cnt = 16, FF = 1, no OVF. Draining yields 16'h8001 as the last word.
- Wrap: 8 writes, 8 reads, then 16 writes of walking ones 16'h0001..16'h8000 -> reads return the walking-ones sequence in order across the pointer wrap.
- pFWFT = 1, pWidth = 8, pAddr = 3:
  - Write 8'hA5 into an empty FIFO -> DO = 8'hA5 the cycle after the write, EF = 0.
  - RE -> EF = 1.
  - Empty + WE & RE with 8'h3C -> Cnt = 1, DO = 8'h3C, UNF = 1.
- Clr with Cnt = 9 and WE = 1 in the same cycle -> Cnt = 0, EF = 1, OVF = 0, UNF = 0, and no write occurs. A subsequent write/read round-trip is correct.

Source files
------------

// File: rtl/dpsf_fifo_ce.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through
// read, programmable almost flags, synchronous clear and sticky error flags.
module dpsf_fifo_ce #(
    parameter int pWidth = 16,
    parameter int pAddr  = 4,
    parameter int pFWFT  = 0,
    parameter int pAFLvl = 12,
    parameter int pAELvl = 4
) (
    input  logic              Clk,
    input  logic              nRst,
    input  logic              Clr,
    input  logic              WE,
    input  logic              RE,
    input  logic [pWidth-1:0] DI,
    output logic [pWidth-1:0] DO,
    output logic              FF,
    output logic              EF,
    output logic              HF,
    output logic              AF,
    output logic              AE,
    output logic              OVF,
    output logic              UNF,
    output logic [pAddr:0]    Cnt
);

    localparam int DEPTH = 1 << pAddr;
    localparam logic [pAddr:0] FULL_C = (pAddr+1)'(DEPTH);
    localparam logic [pAddr:0] HALF_C = (pAddr+1)'(DEPTH / 2);
    localparam logic [pAddr:0] AF_C   = (pAddr+1)'(pAFLvl);
    localparam logic [pAddr:0] AE_C   = (pAddr+1)'(pAELvl);

    logic [pWidth-1:0] mem_q [DEPTH];
    logic [pAddr-1:0]  wa_q, wa_d;
    logic [pAddr-1:0]  ra_q, ra_d;
    logic [pAddr:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rd, wr;

    assign FF  = (cnt_q == FULL_C);
    assign EF  = (cnt_q == '0);
    assign HF  = (cnt_q >= HALF_C);
    assign AF  = (cnt_q >= AF_C);
    assign AE  = (cnt_q <= AE_C);
    assign OVF = ovf_q;
    assign UNF = unf_q;
    assign Cnt = cnt_q;

    // A full FIFO still takes a write when a read frees the slot this cycle
    assign rd = RE & ~EF;
    assign wr = WE & (~FF | rd);

    always_comb begin
        wa_d  = wa_q;
        ra_d  = ra_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (Clr) begin
            wa_d  = '0;
            ra_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (wr) wa_d = wa_q + 1'b1;
            if (rd) ra_d = ra_q + 1'b1;
            if (wr && !rd) cnt_d = cnt_q + 1'b1;
            if (rd && !wr) cnt_d = cnt_q - 1'b1;
            ovf_d = ovf_q | (WE & FF & ~rd);
            unf_d = unf_q | (RE & EF);
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            wa_q  <= '0;
            ra_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wa_q  <= wa_d;
            ra_q  <= ra_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is not reset; a write racing an asserted reset is dropped
    always_ff @(posedge Clk) begin
        if (nRst && !Clr && wr) mem_q[wa_q] <= DI;
    end

    generate
        if (pFWFT == 0) begin : g_reg_rd
            logic [pWidth-1:0] do_q;
            always_ff @(posedge Clk or negedge nRst) begin
                if (!nRst) begin
                    do_q <= '0;
                end else if (Clr) begin
                    do_q <= '0;
                end else if (rd) begin
                    do_q <= mem_q[ra_q];
                end
            end
            assign DO = do_q;
        end else begin : g_fwft_rd
            assign DO = mem_q[ra_q];
        end
    endgenerate

endmodule

// File: tb/tb_dpsf_fifo_ce.sv
// Directed bench: default 16x16 registered-read instance plus an
// 8-bit, 8-deep FWFT instance sharing one clock.
module tb_dpsf_fifo_ce;

    logic Clk = 1'b0;
    logic nRst = 1'b0;
    always #5 Clk = ~Clk;

    logic        clr0 = 0, we0 = 0, re0 = 0;
    logic [15:0] di0 = '0, do0;
    logic        ff0, ef0, hf0, af0, ae0, ovf0, unf0;
    logic [4:0]  cnt0;

    logic        clr1 = 0, we1 = 0, re1 = 0;
    logic [7:0]  di1 = '0, do1;
    logic        ff1, ef1, hf1, af1, ae1, ovf1, unf1;
    logic [3:0]  cnt1;

    int checks = 0;
    int failures = 0;

    dpsf_fifo_ce u0 (
        .Clk(Clk), .nRst(nRst), .Clr(clr0), .WE(we0), .RE(re0),
        .DI(di0), .DO(do0), .FF(ff0), .EF(ef0), .HF(hf0), .AF(af0),
        .AE(ae0), .OVF(ovf0), .UNF(unf0), .Cnt(cnt0)
    );

    dpsf_fifo_ce #(
        .pWidth(8), .pAddr(3), .pFWFT(1), .pAFLvl(6), .pAELvl(2)
    ) u1 (
        .Clk(Clk), .nRst(nRst), .Clr(clr1), .WE(we1), .RE(re1),
        .DI(di1), .DO(do1), .FF(ff1), .EF(ef1), .HF(hf1), .AF(af1),
        .AE(ae1), .OVF(ovf1), .UNF(unf1), .Cnt(cnt1)
    );

    typedef struct {
        logic        we, re, clr;
        logic [15:0] di;
        logic        chk_do;
        logic [15:0] exp_do;
        int          exp_cnt;
        logic [6:0]  exp_fl;
    } vec_t;

    vec_t vecs [35];

    // {FF,EF,HF,AF,AE,OVF,UNF} for the 16-deep instance, AF>=12, AE<=4
    function automatic logic [6:0] fl(int c, logic o, logic u);
        return {c == 16, c == 0, c >= 8, c >= 12, c <= 4, o, u};
    endfunction

    function automatic logic [15:0] pat(int i);
        logic [15:0] base = 16'h1111;
        return (i == 16) ? 16'h0000 : 16'(base * i);
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk0(input string nm, input int c, input logic [6:0] f);
        check({nm, " cnt"}, 32'(cnt0), 32'(c));
        check({nm, " flags"}, 32'({ff0, ef0, hf0, af0, ae0, ovf0, unf0}),
              32'(f));
    endtask

    task automatic op0(input logic we, input logic re, input logic clr,
                       input logic [15:0] di);
        @(negedge Clk);
        we0 = we; re0 = re; clr0 = clr; di0 = di;
        @(posedge Clk);
        #1;
        we0 = 0; re0 = 0; clr0 = 0;
    endtask

    task automatic op1(input logic we, input logic re, input logic [7:0] di);
        @(negedge Clk);
        we1 = we; re1 = re; di1 = di;
        @(posedge Clk);
        #1;
        we1 = 0; re1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 1; i <= 16; i++)
            vecs[i-1] = '{1, 0, 0, pat(i), 0, 16'h0, i, fl(i, 0, 0)};
        vecs[16] = '{1, 0, 0, 16'h0001, 0, 16'h0, 16, fl(16, 1, 0)};
        for (int i = 1; i <= 16; i++)
            vecs[16+i] = '{0, 1, 0, 16'h0, 1, pat(i), 16 - i,
                           fl(16 - i, 1, 0)};
        vecs[33] = '{0, 1, 0, 16'h0, 1, 16'h0000, 0, fl(0, 1, 1)};
        vecs[34] = '{0, 0, 1, 16'h0, 1, 16'h0000, 0, fl(0, 0, 0)};

        #2;
        chk0("reset", 0, fl(0, 0, 0));
        check("reset do", 32'(do0), 32'h0);
        @(negedge Clk);
        nRst = 1'b1;

        foreach (vecs[k]) begin
            op0(vecs[k].we, vecs[k].re, vecs[k].clr, vecs[k].di);
            chk0($sformatf("vec%0d", k), vecs[k].exp_cnt, vecs[k].exp_fl);
            if (vecs[k].chk_do)
                check($sformatf("vec%0d do", k), 32'(do0),
                      32'(vecs[k].exp_do));
        end

        for (int i = 1; i <= 16; i++) op0(1, 0, 0, 16'(16'h0100 + i));
        op0(1, 1, 0, 16'h8001);
        chk0("full rw", 16, fl(16, 0, 0));
        check("full rw do", 32'(do0), 32'h0101);
        for (int j = 1; j <= 16; j++) begin
            op0(0, 1, 0, 16'h0);
            check($sformatf("drain%0d do", j), 32'(do0),
                  (j == 16) ? 32'h8001 : 32'(16'h0101 + j));
        end
        chk0("drained", 0, fl(0, 0, 0));

        op0(0, 0, 1, 16'h0);
        for (int i = 0; i < 8; i++) op0(1, 0, 0, 16'(16'hA000 + i));
        for (int i = 0; i < 8; i++) op0(0, 1, 0, 16'h0);
        check("wrap pre do", 32'(do0), 32'hA007);
        for (int i = 0; i < 16; i++) op0(1, 0, 0, 16'(1 << i));
        chk0("wrap full", 16, fl(16, 0, 0));
        for (int i = 0; i < 16; i++) begin
            op0(0, 1, 0, 16'h0);
            check($sformatf("wrap%0d do", i), 32'(do0), 32'(1 << i));
        end

        op0(0, 1, 0, 16'h0);
        chk0("unf set", 0, fl(0, 0, 1));
        for (int i = 0; i < 9; i++) op0(1, 0, 0, 16'(16'h0C00 + i));
        chk0("pre clr", 9, fl(9, 0, 1));
        op0(1, 0, 1, 16'hDEAD);
        chk0("clr", 0, fl(0, 0, 0));
        check("clr do", 32'(do0), 32'h0);
        op0(1, 0, 0, 16'hBEEF);
        op0(0, 1, 0, 16'h0);
        check("post clr do", 32'(do0), 32'hBEEF);
        chk0("post clr", 0, fl(0, 0, 0));

        for (int i = 1; i <= 6; i++) op0(1, 0, 0, 16'(16'h5000 + i));
        op0(0, 1, 0, 16'h0);
        chk0("pre rst", 5, fl(5, 0, 0));
        check("pre rst do", 32'(do0), 32'h5001);
        #2;
        nRst = 1'b0;
        #1;
        check("async rst no edge", 32'(Clk), 32'h1);
        chk0("async rst", 0, fl(0, 0, 0));
        check("async rst do", 32'(do0), 32'h0);
        @(negedge Clk);
        nRst = 1'b1;

        op1(1, 0, 8'hA5);
        check("fwft wr do", 32'(do1), 32'hA5);
        check("fwft wr ef", 32'(ef1), 32'h0);
        check("fwft wr cnt", 32'(cnt1), 32'h1);
        op1(0, 1, 8'h00);
        check("fwft rd ef", 32'(ef1), 32'h1);
        check("fwft rd cnt", 32'(cnt1), 32'h0);
        op1(1, 1, 8'h3C);
        check("fwft wr+rd cnt", 32'(cnt1), 32'h1);
        check("fwft wr+rd do", 32'(do1), 32'h3C);
        check("fwft wr+rd unf", 32'(unf1), 32'h1);
        op1(1, 0, 8'h77);
        check("fwft head hold", 32'(do1), 32'h3C);
        op1(0, 1, 8'h00);
        check("fwft next do", 32'(do1), 32'h77);
        check("fwft next cnt", 32'(cnt1), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
